twi_slave: RTL and testbench

TWI_SLAVE -- requirements
Module: twi_slave

---
 rtl/twi_slave.sv | 183 ++++++++++++++++++
 tb/tb_twi_slave.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/twi_slave.sv
// TWI (I2C-style) slave: oversampled scl/sda, 7-bit address match, byte read/write
// with ACK handling. All outputs are registered; START/STOP override any bit processing.
module twi_slave #(
  parameter logic [6:0] ADDR = 7'b0111000
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       scl,
  input  logic       sdaIn,
  output logic       sdaOut,
  output logic       sdaOutEn,
  input  logic [7:0] dataOut,
  output logic [7:0] dataIn,
  output logic       dataInValid,
  output logic       dataOutReq
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT
  } state_t;

  // 2-flop synchronizers plus one history flop for edge detection
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sdaIn;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
  assign scl_rise  =  scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q &  scl_prev_q;
  assign sda_rise  =  sda_sync_q & ~sda_prev_q;
  assign sda_fall  = ~sda_sync_q &  sda_prev_q;
  assign start_det =  sda_fall & scl_sync_q;
  assign stop_det  =  sda_rise & scl_sync_q;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [7:0]  shift_q;
  logic        rw_q;
  logic        mack_q;
  logic        sda_o_q, sda_oe_q;
  logic [7:0]  data_in_q;
  logic        din_vld_q, dout_req_q;

  logic [7:0] rx_byte;
  assign rx_byte = {shift_q[6:0], sda_sync_q};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
      sda_o_q    <= 1'b1;
      sda_oe_q   <= 1'b0;
      data_in_q  <= 8'h00;
      din_vld_q  <= 1'b0;
      dout_req_q <= 1'b0;
    end else begin
      din_vld_q  <= 1'b0;
      dout_req_q <= 1'b0;
      if (start_det) begin
        state_q  <= S_ADDR;
        cnt_q    <= 3'd0;
        sda_oe_q <= 1'b0;
        sda_o_q  <= 1'b1;
      end else if (stop_det) begin
        state_q  <= S_IDLE;
        cnt_q    <= 3'd0;
        sda_oe_q <= 1'b0;
        sda_o_q  <= 1'b1;
      end else begin
        case (state_q)
          S_ADDR: if (scl_rise) begin
            shift_q <= rx_byte;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (rx_byte[7:1] == ADDR) begin
                state_q <= S_ADDR_ACK;
                rw_q    <= rx_byte[0];
              end else begin
                state_q <= S_WAIT;
              end
            end
          end
          // First fall drives ACK; the second fall ends the ACK clock.
          S_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
              sda_o_q  <= 1'b0;
            end else if (rw_q) begin
              state_q    <= S_TX;
              cnt_q      <= 3'd0;
              shift_q    <= dataOut;
              sda_o_q    <= dataOut[7];
              dout_req_q <= 1'b1;
            end else begin
              state_q  <= S_RX;
              cnt_q    <= 3'd0;
              sda_oe_q <= 1'b0;
              sda_o_q  <= 1'b1;
            end
          end
          S_RX: if (scl_rise) begin
            shift_q <= rx_byte;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              data_in_q <= rx_byte;
              din_vld_q <= 1'b1;
              state_q   <= S_RX_ACK;
            end
          end
          S_RX_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
              sda_o_q  <= 1'b0;
            end else begin
              state_q  <= S_RX;
              cnt_q    <= 3'd0;
              sda_oe_q <= 1'b0;
              sda_o_q  <= 1'b1;
            end
          end
          S_TX: if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              state_q  <= S_TX_ACK;
              cnt_q    <= 3'd0;
              mack_q   <= 1'b0;
              sda_oe_q <= 1'b0;
              sda_o_q  <= 1'b1;
            end else begin
              cnt_q   <= cnt_q + 3'd1;
              shift_q <= {shift_q[6:0], 1'b0};
              sda_o_q <= shift_q[6];
            end
          end
          S_TX_ACK: begin
            if (scl_rise) begin
              if (sda_sync_q) state_q <= S_WAIT;
              else            mack_q  <= 1'b1;
            end else if (scl_fall && mack_q) begin
              state_q    <= S_TX;
              cnt_q      <= 3'd0;
              mack_q     <= 1'b0;
              shift_q    <= dataOut;
              sda_oe_q   <= 1'b1;
              sda_o_q    <= dataOut[7];
              dout_req_q <= 1'b1;
            end
          end
          default: begin
            sda_oe_q <= 1'b0;
            sda_o_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sdaOut      = sda_o_q;
  assign sdaOutEn    = sda_oe_q;
  assign dataIn      = data_in_q;
  assign dataInValid = din_vld_q;
  assign dataOutReq  = dout_req_q;

endmodule

// File: tb/tb_twi_slave.sv
// Directed bench for twi_slave: a bus-level master drives scl/sda with wired-AND
// resolution against the slave's drive, and checks ACKs, read data, pulses and reset.
module tb_twi_slave;

  logic       clk = 1'b0;
  logic       rstN;
  logic       scl;
  logic       m_sda;
  logic       sdaOut, sdaOutEn;
  logic [7:0] dataOut;
  logic [7:0] dataIn;
  logic       dataInValid, dataOutReq;
  logic       sda_bus;

  int passed = 0;
  int total  = 0;
  int vld_cnt = 0, req_cnt = 0, en_cnt = 0;

  assign sda_bus = m_sda & (sdaOutEn ? sdaOut : 1'b1);

  twi_slave #(.ADDR(7'b0111000)) dut (
    .clk(clk), .rstN(rstN), .scl(scl), .sdaIn(sda_bus),
    .sdaOut(sdaOut), .sdaOutEn(sdaOutEn),
    .dataOut(dataOut), .dataIn(dataIn),
    .dataInValid(dataInValid), .dataOutReq(dataOutReq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dataInValid) vld_cnt++;
    if (dataOutReq)  req_cnt++;
    if (sdaOutEn)    en_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One scl clock: master puts b on sda while scl low, returns the resolved bus mid-high.
  task automatic bit_clk(input logic b, output logic s);
    m_sda = b;  wclk(4);
    scl   = 1'b1; wclk(4);
    s     = sda_bus; wclk(4);
    scl   = 1'b0; wclk(4);
  endtask

  task automatic start_c();
    m_sda = 1'b1; wclk(4);
    scl   = 1'b1; wclk(8);
    m_sda = 1'b0; wclk(8);
    scl   = 1'b0; wclk(4);
  endtask

  task automatic stop_c();
    m_sda = 1'b0; wclk(4);
    scl   = 1'b1; wclk(8);
    m_sda = 1'b1; wclk(8);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_clk(b[i], s);
    bit_clk(1'b1, ack);
  endtask

  task automatic read_bits(input int n, output logic [7:0] v);
    logic s;
    v = 8'h00;
    for (int i = 0; i < n; i++) begin
      bit_clk(1'b1, s);
      v = {v[6:0], s};
    end
  endtask

  logic       ack, s;
  logic [7:0] rd;
  int         req0, vld0, en0;

  initial begin
    rstN = 1'b0; scl = 1'b1; m_sda = 1'b1; dataOut = 8'h00;
    wclk(3);
    chk("rst_sdaOutEn", {7'd0, sdaOutEn}, 8'h00);
    chk("rst_sdaOut", {7'd0, sdaOut}, 8'h01);
    chk("rst_dataIn", dataIn, 8'h00);
    chk("rst_dataInValid", {7'd0, dataInValid}, 8'h00);
    chk("rst_dataOutReq", {7'd0, dataOutReq}, 8'h00);
    rstN = 1'b1; wclk(3);

    // Read: AA with master ACK, then 3C, then master NACK
    dataOut = 8'hAA; req0 = req_cnt;
    start_c();
    write_byte(8'h71, ack);
    chk("rd_addr_ack", {7'd0, ack}, 8'h00);
    read_bits(8, rd);
    chk("rd_byte1", rd, 8'hAA);
    chk("rd_req1", 8'(req_cnt - req0), 8'd1);
    dataOut = 8'h3C;
    bit_clk(1'b0, s);
    read_bits(8, rd);
    chk("rd_byte2", rd, 8'h3C);
    chk("rd_req2", 8'(req_cnt - req0), 8'd2);
    bit_clk(1'b1, s);
    chk("nack_released", {7'd0, sdaOutEn}, 8'h00);
    en0 = en_cnt;
    read_bits(8, rd);
    chk("wait_bus_idle", rd, 8'hFF);
    chk("wait_no_drive", 8'(en_cnt - en0), 8'd0);
    stop_c();

    // Write: address then 5C
    vld0 = vld_cnt;
    start_c();
    write_byte(8'h70, ack);
    chk("wr_addr_ack", {7'd0, ack}, 8'h00);
    write_byte(8'h5C, ack);
    chk("wr_data_ack", {7'd0, ack}, 8'h00);
    chk("wr_dataIn", dataIn, 8'h5C);
    chk("wr_vld_once", 8'(vld_cnt - vld0), 8'd1);
    stop_c();

    // Address mismatch: no ACK, following byte ignored
    en0 = en_cnt; vld0 = vld_cnt;
    start_c();
    write_byte(8'h72, ack);
    chk("nomatch_nack", {7'd0, ack}, 8'h01);
    write_byte(8'h55, ack);
    chk("nomatch_no_drive", 8'(en_cnt - en0), 8'd0);
    chk("nomatch_no_vld", 8'(vld_cnt - vld0), 8'd0);
    stop_c();

    // STOP in the middle of a read byte (slave driving bit3 = 1)
    dataOut = 8'h3C;
    start_c();
    write_byte(8'h71, ack);
    chk("stop_addr_ack", {7'd0, ack}, 8'h00);
    read_bits(3, rd);
    chk("stop_partial", rd, 8'h01);
    m_sda = 1'b0; wclk(4);
    scl   = 1'b1; wclk(8);
    m_sda = 1'b1; wclk(3);
    chk("stop_release_3clk", {7'd0, sdaOutEn}, 8'h00);
    wclk(8);
    scl = 1'b0; wclk(4);
    en0 = en_cnt;
    write_byte(8'h71, ack);
    chk("idle_ignore_scl", 8'(en_cnt - en0), 8'd0);

    // Async reset while the slave drives the address ACK
    scl = 1'b1; m_sda = 1'b1; wclk(8);
    start_c();
    for (int i = 7; i >= 0; i--) begin
      rd = 8'h70;
      bit_clk(rd[i], s);
    end
    m_sda = 1'b1; wclk(4);
    chk("ack_driven", {7'd0, sdaOutEn}, 8'h01);
    rstN = 1'b0; #1;
    chk("async_rst_oe", {7'd0, sdaOutEn}, 8'h00);
    chk("async_rst_o", {7'd0, sdaOut}, 8'h01);
    wclk(2); rstN = 1'b1;
    scl = 1'b1; wclk(8);
    scl = 1'b0; wclk(4);
    en0 = en_cnt;
    write_byte(8'h70, ack);
    chk("post_rst_no_ack", {7'd0, ack}, 8'h01);
    chk("post_rst_no_drive", 8'(en_cnt - en0), 8'd0);
    scl = 1'b1; wclk(8);
    start_c();
    write_byte(8'h70, ack);
    chk("post_rst_start_ack", {7'd0, ack}, 8'h00);
    write_byte(8'h11, ack);
    chk("post_rst_dataIn", dataIn, 8'h11);
    stop_c();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
